// File: rtl/serial_seq_detect_core.sv
// Serializes a 4-bit stimulus word MSB first and scans the stream for the
// overlapping pattern 1011 with a Moore and a Mealy detector side by side.

module par2ser (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] data_parallel,
    output logic       data_serial
);

    logic [1:0] cnt;
    logic [3:0] sh;

    // A new word is captured only in slot 0; the other three slots shift it out.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            cnt <= 2'd0;
            sh  <= 4'd0;
        end else begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd0)
                sh <= data_parallel;
            else
                sh <= {sh[2:0], 1'b0};
        end
    end

    assign data_serial = sh[3];

endmodule

module sequence_detector_moore (
    input  logic clk,
    input  logic reset_n,
    input  logic data_serial,
    input  logic data_valid,
    output logic moore_detected
);

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } moore_state_t;

    moore_state_t state;
    moore_state_t next_state;

    always_ff @(posedge clk) begin
        if (reset_n)
            state <= S0;
        else
            state <= next_state;
    end

    // An invalid cycle discards any partial match; encodings 5..7 fall back to S0.
    always_comb begin
        next_state     = S0;
        moore_detected = (state == S4);
        if (data_valid) begin
            case (state)
                S0:      next_state = data_serial ? S1 : S0;
                S1:      next_state = data_serial ? S1 : S2;
                S2:      next_state = data_serial ? S3 : S0;
                S3:      next_state = data_serial ? S4 : S2;
                S4:      next_state = data_serial ? S1 : S2;
                default: next_state = S0;
            endcase
        end
    end

endmodule

module sequence_detector_mealy (
    input  logic clk,
    input  logic reset_n,
    input  logic data_serial,
    input  logic data_valid,
    output logic mealy_detected
);

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } mealy_state_t;

    mealy_state_t state;
    mealy_state_t next_state;

    always_ff @(posedge clk) begin
        if (reset_n)
            state <= S0;
        else
            state <= next_state;
    end

    // Completing 1011 from S3 leaves the trailing 1 as the start of the next match.
    always_comb begin
        next_state     = S0;
        mealy_detected = data_valid & (state == S3) & data_serial;
        if (data_valid) begin
            case (state)
                S0:      next_state = data_serial ? S1 : S0;
                S1:      next_state = data_serial ? S1 : S2;
                S2:      next_state = data_serial ? S3 : S0;
                S3:      next_state = data_serial ? S1 : S2;
                default: next_state = S0;
            endcase
        end
    end

endmodule

module serial_seq_detect_core (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] data_parallel,
    input  logic       data_valid,
    output logic       data_serial,
    output logic       moore_detected,
    output logic       mealy_detected
);

    par2ser u_par2ser (
        .clk           (clk),
        .reset_n       (reset_n),
        .data_parallel (data_parallel),
        .data_serial   (data_serial)
    );

    sequence_detector_moore u_moore (
        .clk            (clk),
        .reset_n        (reset_n),
        .data_serial    (data_serial),
        .data_valid     (data_valid),
        .moore_detected (moore_detected)
    );

    sequence_detector_mealy u_mealy (
        .clk            (clk),
        .reset_n        (reset_n),
        .data_serial    (data_serial),
        .data_valid     (data_valid),
        .mealy_detected (mealy_detected)
    );

endmodule

// File: tb/tb_serial_seq_detect_core.sv
// Directed bench for serial_seq_detect_core: per-cycle hand-computed expectations
// for the serial stream and both detector pulses.

module tb_serial_seq_detect_core;

    logic       clk;
    logic       reset_n;
    logic [3:0] data_parallel;
    logic       data_valid;
    logic       data_serial;
    logic       moore_detected;
    logic       mealy_detected;

    int passCount;
    int totalCount;

    serial_seq_detect_core dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .data_parallel  (data_parallel),
        .data_valid     (data_valid),
        .data_serial    (data_serial),
        .moore_detected (moore_detected),
        .mealy_detected (mealy_detected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the edge and hold for the rest of the cycle.
    task automatic applyStimulus(input logic [3:0] w, input logic v, input logic r);
        @(posedge clk);
        #1;
        data_parallel = w;
        data_valid    = v;
        reset_n       = r;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic ds, input logic me, input logic mo);
        totalCount++;
        assert (data_serial === ds) passCount++;
        else $error("[TB] FAIL %s data_serial observed=%b expected=%b", tag, data_serial, ds);
        totalCount++;
        assert (mealy_detected === me) passCount++;
        else $error("[TB] FAIL %s mealy_detected observed=%b expected=%b", tag, mealy_detected, me);
        totalCount++;
        assert (moore_detected === mo) passCount++;
        else $error("[TB] FAIL %s moore_detected observed=%b expected=%b", tag, moore_detected, mo);
    endtask

    task automatic step(input string tag, input logic [3:0] w, input logic v, input logic r,
                        input logic ds, input logic me, input logic mo);
        applyStimulus(w, v, r);
        checkOutput(tag, ds, me, mo);
    endtask

    initial begin
        passCount     = 0;
        totalCount    = 0;
        reset_n       = 1'b1;
        data_parallel = 4'h0;
        data_valid    = 1'b0;

        // Test 1: single 4'hB word right after reset
        applyStimulus(4'h0, 1'b0, 1'b1);
        applyStimulus(4'h0, 1'b0, 1'b1);
        step("t1_c0_reset", 4'hB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t1_c1",       4'hB, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("t1_c2",       4'hB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t1_c3",       4'hB, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("t1_c4_mealy", 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step("t1_c5_moore", 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("t1_c6",       4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Test 2: 4'hB then 4'h6, overlapping detections at bits 4 and 7
        applyStimulus(4'h0, 1'b0, 1'b1);
        step("t2_c0_reset", 4'hB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t2_c1",       4'hB, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("t2_c2",       4'hB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t2_c3",       4'hB, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("t2_c4_mealy", 4'h6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step("t2_c5_moore", 4'h6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("t2_c6",       4'h6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("t2_c7_mealy", 4'h6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step("t2_c8_moore", 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("t2_c9",       4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Test 3: 4'h0, 4'hF, 4'hA never form 1011
        applyStimulus(4'h0, 1'b0, 1'b1);
        step("t3_c0_reset", 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t3_c1",       4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t3_c2",       4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t3_c3",       4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t3_c4",       4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t3_c5",       4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("t3_c6",       4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("t3_c7",       4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("t3_c8",       4'hA, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("t3_c9",       4'hA, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("t3_c10",      4'hA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t3_c11",      4'hA, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("t3_c12",      4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t3_c13",      4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Test 4: 1,0,1 then an invalid cycle on the final 1, then a lone 1
        applyStimulus(4'h0, 1'b0, 1'b1);
        step("t4_c0_reset", 4'hB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t4_c1",       4'hB, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("t4_c2",       4'hB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t4_c3",       4'hB, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("t4_c4_gap",   4'h8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("t4_c5",       4'h8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("t4_c6",       4'h8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Test 5: reset while the Mealy detector sits in S3, then a clean 4'hB
        applyStimulus(4'h0, 1'b0, 1'b1);
        step("t5_c0_reset", 4'hB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t5_c1",       4'hB, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("t5_c2",       4'hB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t5_c3",       4'hB, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("t5_c4_s3",    4'hB, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step("t5_c5_rst",   4'hB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t5_c6",       4'hB, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("t5_c7",       4'hB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t5_c8",       4'hB, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("t5_c9_mealy", 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step("t5_c10_moore",4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("t5_c11",      4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Test 6: 4'hB four times back to back, Moore lags Mealy by one cycle
        applyStimulus(4'h0, 1'b0, 1'b1);
        step("t6_c0_reset", 4'hB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int slot = 0; slot < 4; slot++) begin
            step("t6_b3",       4'hB, 1'b1, 1'b0, 1'b1, 1'b0, (slot != 0));
            step("t6_b2",       4'hB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            step("t6_b1",       4'hB, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            step("t6_b0_mealy", (slot == 3) ? 4'h0 : 4'hB, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        step("t6_last_moore", 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("t6_tail",       4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/serial_seq_detect_core.md
# serial_seq_detect_core

Converts a 4-bit parallel stimulus word into a serial bit stream, MSB first. It then scans that stream for the overlapping pattern 1011 with two detector FSMs running side by side: a Moore detector and a Mealy detector. The block sits between the stimulus source and the detection counters in the sequence-detector lab design. It contains three sub-units: par2ser, sequence_detector_moore and sequence_detector_mealy.

## Interface
- Parameters: none. Word width is fixed at 4 and the pattern is fixed at 1011.
- clk  in  1  single clock; every register updates on the rising edge.
- reset_n  in  1  synchronous, active-high reset, asserted when reset_n=1. The port keeps the codebase name; the polarity is fixed as stated.
- data_parallel  in  4  stimulus word. Must be held stable across each 4-cycle serialization slot.
- data_valid  in  1  qualifies the serial bit currently on data_serial for both detectors.
- data_serial  out  1  serialized stream, MSB first.
- moore_detected  out  1  Moore detection pulse, registered.
- mealy_detected  out  1  Mealy detection pulse, combinational from state and current input.

## Operation
- par2ser: holds a 2-bit slot counter cnt and a 4-bit shift register sh.
  - Each edge with cnt==0: sh<=data_parallel.
  - Otherwise: sh<={sh[2:0],1'b0}.
  - cnt increments every edge and wraps 3->0.
  - data_serial = sh[3].
- Both detectors sample data_serial on each rising edge where data_valid=1.
- An edge with data_valid=0 forces the state to S0, so the partial match is discarded.
- Moore FSM states: S0 (none), S1 ("1"), S2 ("10"), S3 ("101"), S4 ("1011"). Transitions for input 0 / 1:
  - S0: 0->S0, 1->S1
  - S1: 0->S2, 1->S1
  - S2: 0->S0, 1->S3
  - S3: 0->S2, 1->S4
  - S4: 0->S2, 1->S1
- moore_detected = (state==S4).
- Mealy FSM states: S0..S3, with the same meaning and transitions as Moore S0..S3, except S3 on input 1 goes to S1.
- mealy_detected = data_valid & (state==S3) & data_serial.
- Overlap is allowed: the stream 1011011 yields two detections.
- No other state encodings are reachable. An illegal encoding recovers to S0 on the next edge.

## Timing
- Reset, at any edge with reset_n=1, including mid-word or mid-pattern:
  - cnt=0, sh=0 and both FSMs go to S0.
  - data_serial=0, moore_detected=0, mealy_detected=0. mealy_detected is 0 because its state is S0.
- First edge after reset is released: cnt==0, so the first word is loaded.
- Word loaded at edge E: bits 3,2,1,0 appear on data_serial in the cycles after E, E+1, E+2 and E+3.
  - Detectors consume those bits at edges E+1 through E+4.
- A new word is sampled every 4th edge. data_parallel is ignored when cnt!=0.
- Mealy pulse: high during the cycle in which the final 1 of the pattern is on data_serial with data_valid=1. Width is 1 cycle per detection.
- Moore pulse: high exactly one cycle later than the Mealy pulse, for 1 cycle.
  - After S4, the next valid bit leaves S4.
  - An invalid cycle forces S0, so Moore never stays high more than 1 cycle.
- For any stream with data_valid held high, the Moore and Mealy detection counts are equal.
- data_valid dropping in the same cycle as the final bit:
  - Mealy stays 0.
  - Moore stays 0, because the state goes to S0.

## Test plan
- Reset held, then released with data_parallel=4'hB and data_valid=1 from the first edge -> data_serial 1,0,1,1; mealy_detected=1 in the 4th bit cycle; moore_detected=1 in the following cycle; each pulse 1 cycle wide.
- Words 4'hB, 4'h6 with data_valid=1 (stream 10110110) -> 2 Mealy and 2 Moore pulses, at bit 4 and bit 7 (overlap).
- Words 4'h0, 4'hF, 4'hA, each for one slot -> no detection from either FSM.
- Stream 1,0,1 then data_valid=0 for 1 cycle then 1 -> no detection on either output.
- Reset asserted while the Mealy FSM is in S3 -> next cycle all outputs are 0; a following 4'hB word still detects once.
- Words 4'hB repeated 4 times, data_valid=1 (1011 1011 ...) -> 4 detections on each output; the Moore pulse always lags the Mealy pulse by 1 cycle.
